button_event_controller: RTL

//  Sequences one debounce_fsm instance and turns its debounced level into

---
 rtl/button_event_pkg.sv | 19 +
 rtl/button_event_checker.sv | 36 +++
 rtl/debounce_fsm.sv | 42 ++++
 rtl/button_event_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button event controller: event codes and classifier states.
package button_event_pkg;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_SHORT  = 2'd1,
        EV_LONG   = 2'd2,
        EV_DOUBLE = 2'd3
    } event_code_t;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

endpackage

// File: rtl/button_event_checker.sv
// Run-time invariants of the event controller: event register handshake and
// classifier/timer sanity.
module button_event_checker
    import button_event_pkg::*;
#(
    parameter int TIMER_WIDTH = 16
) (
    input logic                   clock,
    input logic                   reset_n,
    input logic                   event_valid,
    input logic                   event_ready,
    input logic [1:0]             event_code,
    input state_t                 state,
    input logic [TIMER_WIDTH-1:0] timer
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO = {TIMER_WIDTH{1'b0}};

    valid_has_code: assert property (@(posedge clock) disable iff (!reset_n)
        event_valid |-> (event_code != 2'd0))
        else $error("event register valid with code 0");

    held_event_stable: assert property (@(posedge clock)
        (event_valid && !event_ready && reset_n) |=> (event_valid && $stable(event_code)))
        else $error("unaccepted event changed or vanished");

    legal_state: assert property (@(posedge clock) disable iff (!reset_n)
        state <= SECOND_PRESSED)
        else $error("classifier in undefined state");

    timer_saturates: assert property (@(posedge clock)
        (reset_n && timer == TIMER_MAX) |=> (timer == TIMER_MAX || timer == TIMER_ZERO))
        else $error("event timer wrapped");

endmodule

// File: rtl/debounce_fsm.sv
// Debouncer: the output follows the raw level only after it has differed from the
// current output for debounce_counter consecutive cycles.
module debounce_fsm #(
    parameter int DEBOUNCE_COUNTER_WIDTH = 24
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              bouncing_signal,
    input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] debounce_counter,
    output logic                              debounced
);

    localparam int CW = DEBOUNCE_COUNTER_WIDTH;

    logic          level_r;
    logic [CW-1:0] count_r;
    logic [CW:0]   count_inc_s;
    logic          settled_s;

    // Widened by one bit so an all-ones threshold cannot wrap the compare.
    assign count_inc_s = {1'b0, count_r} + {{CW{1'b0}}, 1'b1};
    assign settled_s   = (count_inc_s >= {1'b0, debounce_counter});
    assign debounced   = level_r;

    // Level tracking and disagreement counter; reset adopts the raw level directly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_r <= bouncing_signal;
            count_r <= {CW{1'b0}};
        end else if (bouncing_signal == level_r) begin
            level_r <= level_r;
            count_r <= {CW{1'b0}};
        end else if (settled_s) begin
            level_r <= bouncing_signal;
            count_r <= {CW{1'b0}};
        end else begin
            level_r <= level_r;
            count_r <= count_inc_s[CW-1:0];
        end
    end

endmodule

// File: rtl/button_event_controller.sv
// Turns a raw pushbutton into SHORT / LONG / DOUBLE events, delivered through a
// single-entry valid/ready register with a sticky overflow flag.
module button_event_controller
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_COUNTER_WIDTH = 24,
    parameter int TICK_DIVIDER           = 100000,
    parameter int TIMER_WIDTH            = 16
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic                              i_bouncing_signal,
    input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter,
    input  logic [TIMER_WIDTH-1:0]            i_long_press_ticks,
    input  logic [TIMER_WIDTH-1:0]            i_double_click_ticks,
    output logic                              o_event_valid,
    input  logic                              i_event_ready,
    output logic [1:0]                        o_event_code,
    output logic                              o_event_overflow,
    input  logic                              i_overflow_clear
);

    localparam int                     PW         = $clog2(TICK_DIVIDER);
    localparam logic [PW-1:0]          PRESC_LAST = PW'(TICK_DIVIDER - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO = {TIMER_WIDTH{1'b0}};

    logic          debounced_s;
    logic          history_r;
    logic          rise_s;
    logic          fall_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TIMER_WIDTH-1:0] timer_r;
    logic                   emit_s;
    event_code_t            emit_code_s;

    logic        event_valid_r;
    event_code_t event_code_r;
    logic        event_overflow_r;
    logic        accept_s;

    debounce_fsm #(
        .DEBOUNCE_COUNTER_WIDTH(DEBOUNCE_COUNTER_WIDTH)
    ) u_debounce (
        .clock           (i_clock),
        .reset_n         (i_reset_n),
        .bouncing_signal (i_bouncing_signal),
        .debounce_counter(i_debounce_counter),
        .debounced       (debounced_s)
    );

    assign rise_s = debounced_s & ~history_r;
    assign fall_s = ~debounced_s & history_r;
    assign tick_s = (presc_r == PRESC_LAST);

    // History register; loading it during reset too keeps a held button from
    // looking like a fresh press once reset is released.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            history_r <= debounced_s;
        end else begin
            history_r <= debounced_s;
        end
    end

    // Free-running tick prescaler.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1'b1);
        end
    end

    // Classification: next state and event to emit, acting in the edge-detect cycle.
    always_comb begin
        state_nxt_s = state_r;
        emit_s      = 1'b0;
        emit_code_s = EV_NONE;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = PRESSED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESSED: begin
                if (fall_s) begin
                    if (i_double_click_ticks == TIMER_ZERO) begin
                        state_nxt_s = IDLE;
                        emit_s      = 1'b1;
                        emit_code_s = EV_SHORT;
                    end else begin
                        state_nxt_s = WAIT_SECOND;
                    end
                end else if ((i_long_press_ticks != TIMER_ZERO) &&
                             (timer_r >= i_long_press_ticks)) begin
                    state_nxt_s = LONG_HELD;
                    emit_s      = 1'b1;
                    emit_code_s = EV_LONG;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            LONG_HELD: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LONG_HELD;
                end
            end
            WAIT_SECOND: begin
                if (rise_s) begin
                    state_nxt_s = SECOND_PRESSED;
                end else if (timer_r >= i_double_click_ticks) begin
                    state_nxt_s = IDLE;
                    emit_s      = 1'b1;
                    emit_code_s = EV_SHORT;
                end else begin
                    state_nxt_s = WAIT_SECOND;
                end
            end
            SECOND_PRESSED: begin
                if (fall_s) begin
                    state_nxt_s = IDLE;
                    emit_s      = 1'b1;
                    emit_code_s = EV_DOUBLE;
                end else begin
                    state_nxt_s = SECOND_PRESSED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and saturating tick timer, cleared on every state change.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
            timer_r <= TIMER_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                timer_r <= TIMER_ZERO;
            end else if (tick_s && (timer_r != TIMER_MAX)) begin
                timer_r <= timer_r + TIMER_WIDTH'(1'b1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    assign accept_s = event_valid_r & i_event_ready;

    // Single-entry event register; a new event overwrites only a slot that is
    // empty or leaving this cycle, otherwise it is dropped and flagged.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            event_valid_r    <= 1'b0;
            event_code_r     <= EV_NONE;
            event_overflow_r <= 1'b0;
        end else begin
            if (emit_s && (!event_valid_r || accept_s)) begin
                event_valid_r <= 1'b1;
                event_code_r  <= emit_code_s;
            end else if (accept_s) begin
                event_valid_r <= 1'b0;
                event_code_r  <= event_code_r;
            end else begin
                event_valid_r <= event_valid_r;
                event_code_r  <= event_code_r;
            end
            if (emit_s && event_valid_r && !accept_s) begin
                event_overflow_r <= 1'b1;
            end else if (i_overflow_clear) begin
                event_overflow_r <= 1'b0;
            end else begin
                event_overflow_r <= event_overflow_r;
            end
        end
    end

    assign o_event_valid    = event_valid_r;
    assign o_event_code     = event_code_r;
    assign o_event_overflow = event_overflow_r;

    button_event_checker #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_checker (
        .clock      (i_clock),
        .reset_n    (i_reset_n),
        .event_valid(event_valid_r),
        .event_ready(i_event_ready),
        .event_code (event_code_r),
        .state      (state_r),
        .timer      (timer_r)
    );

endmodule
